rf_write_arbiter: RTL
=====================

Name: rf_write_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters: ALU/CSR writeback (port 0) and load writeback (port 1).
- Grants at most one write per cycle and registers the winner.
- Its outputs wr_en/wr_addr drive the register file's 5-to-32 write-enable decoder (en/A) and write-data bus.
- Suppresses writes to x0, so the decoder is never enabled for register 0.

Parameters:
- ADDR_W, 5, register index width; the RV32I register file has 32 entries.
- DATA_W, 32, write data width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- hold  in  1  pipeline freeze; while 1, no grants are issued.
- req0_valid  in  1  ALU writeback request.
- req0_rd  in  ADDR_W  destination register, port 0.
- req0_data  in  DATA_W  write data, port 0.
- req0_ready  out  1  grant to port 0 (combinational).
- req1_valid  in  1  load writeback request.
- req1_rd  in  ADDR_W  destination register, port 1.
- req1_data  in  DATA_W  write data, port 1.
- req1_ready  out  1  grant to port 1 (combinational).
- wr_en  out  1  registered write enable to the decoder en input.
- wr_addr  out  ADDR_W  registered write index to the decoder A input.
- wr_data  out  DATA_W  registered write data.
- last_grant  out  1  index of the most recently granted port (debug/perf).

Behaviour:
- Reset (rst=1 at a clock edge):
  - wr_en=0, wr_addr=0, wr_data=0, last_grant=1.
  - Applies even mid-transfer: an accepted but not yet written request is dropped.
  - While rst is asserted, ready outputs are 0.
- Handshake:
  - A transfer occurs on port i when reqi_valid & reqi_ready at a rising edge.
  - A requester must hold valid, rd and data stable until accepted.
  - The arbiter never grants a port whose valid is 0.
- Grant, combinational:
  - hold=1: both ready=0.
  - Only one valid: that port is granted.
  - Both valid: the port not equal to last_grant is granted (round-robin).
  - Neither valid: no grant.
  - Exactly one ready is high at most.
- Pointer update: last_grant takes the granted index on any transfer; it is unchanged otherwise.
- Output register, latency 1 cycle from accept to wr_en:
  - On a transfer: wr_addr<=rd, wr_data<=data, wr_en<=(rd!=0).
  - On no transfer: wr_en<=0; wr_addr and wr_data hold their values.
- x0 writes: accepted (ready asserted, pointer advances), but wr_en stays 0.
- Fairness: under continuous contention, grants alternate 0,1,0,1…; no port waits more than 1 cycle.
- Same rd on both ports in one cycle: writes are serialized in grant order; the second write lands last.
- hold asserted while a write is registered: the registered write still completes, and hold blocks only new grants.
- Throughput: one write per cycle; no internal buffering beyond the output register.

Optional Feature:
- Macro: RF_ARB_LOAD_PRIORITY_EN.
- Defined: fixed priority. Port 1 (load) always wins contention. last_grant still tracks the granted port but does not affect selection.
- Undefined: round-robin as specified above.

Decomposition:
- Shared package holds:
  - constants RF_ADDR_W=5, RF_DATA_W=32, RF_ZERO_REG=0;
  - port index constants WB_PORT_ALU=0, WB_PORT_LOAD=1;
  - a typedef for the writeback request bundle {valid, rd, data}.
- One sub-module is natural: rr_arb2. It is the 2-way arbiter holding the last_grant pointer, with inputs valid[1:0] and hold, and outputs grant[1:0]. The macro is handled inside it.
- The top level holds the data mux and output register.

Test Plan:
- Reset: assert rst for 2 cycles while req0_valid=1, rd=5 -> wr_en=0, wr_addr=0, both ready=0, last_grant=1. Release rst -> port 0 granted the same cycle; next cycle wr_en=1, wr_addr=5.
- Single request: req1 rd=10, data=0xDEADBEEF for 1 cycle -> req1_ready=1 that cycle; next cycle wr_en=1, wr_addr=10, wr_data=0xDEADBEEF; the cycle after, wr_en=0.
- Contention: both valid for 4 cycles (rd0=1, rd1=2), each dropping valid once accepted then re-requesting -> grant order 0,1,0,1; wr_addr sequence 1,2,1,2.
- x0 suppression: req0 rd=0, data=0x1234 -> req0_ready=1 and last_grant=0, but wr_en stays 0 the next cycle.
- Hold: both valid with hold=1 for 3 cycles -> no ready and wr_en=0. Release hold -> port 0 granted (last_grant was 1).
- Same-rd conflict: both valid, rd=7, data0=0xA, data1=0xB -> two consecutive writes; final wr_data=0xB under round-robin from reset, and under RF_ARB_LOAD_PRIORITY_EN the order is 0xB then 0xA.

Source files
------------

// File: rtl/rf_write_arbiter_pkg.sv
// Shared constants and the writeback request bundle for the register-file write arbiter.
package rf_write_arbiter_pkg;

  localparam int RF_ADDR_W   = 5;
  localparam int RF_DATA_W   = 32;
  localparam int RF_ZERO_REG = 0;

  localparam int WB_PORT_ALU  = 0;
  localparam int WB_PORT_LOAD = 1;

  typedef struct packed {
    logic                 valid;
    logic [RF_ADDR_W-1:0] rd;
    logic [RF_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rf_write_arbiter_rr_arb2.sv
// Two-way writeback arbiter with last-grant pointer.
// Contention policy: round-robin, or fixed load priority when RF_ARB_LOAD_PRIORITY_EN is defined.
module rr_arb2
  import rf_write_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       hold,
  input  logic [1:0] valid,
  output logic [1:0] grant,
  output logic       last_grant
);

  always_comb begin
    grant = '0;
    if (!rst && !hold) begin
      if (valid == 2'b11) begin
`ifdef RF_ARB_LOAD_PRIORITY_EN
        grant[WB_PORT_LOAD] = 1'b1;
`else
        // Contention goes to the port that did not win last time.
        if (last_grant) grant[WB_PORT_ALU]  = 1'b1;
        else            grant[WB_PORT_LOAD] = 1'b1;
`endif
      end else begin
        grant = valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      last_grant <= 1'b1;
    else if (|grant)
      last_grant <= grant[WB_PORT_LOAD];
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: grants one writeback per cycle and registers it.
// Optional fixed load priority via RF_ARB_LOAD_PRIORITY_EN (see rr_arb2).
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_rd,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_rd,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              last_grant
);

  logic [1:0]        grant;
  logic              xfer;
  logic [ADDR_W-1:0] rd_sel;
  logic [DATA_W-1:0] data_sel;

  rr_arb2 u_arb (
    .clk        (clk),
    .rst        (rst),
    .hold       (hold),
    .valid      ({req1_valid, req0_valid}),
    .grant      (grant),
    .last_grant (last_grant)
  );

  assign req0_ready = grant[WB_PORT_ALU];
  assign req1_ready = grant[WB_PORT_LOAD];
  assign xfer       = |grant;
  assign rd_sel     = grant[WB_PORT_LOAD] ? req1_rd   : req0_rd;
  assign data_sel   = grant[WB_PORT_LOAD] ? req1_data : req0_data;

  // x0 writes are consumed but never reach the decoder enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= xfer && (rd_sel != ADDR_W'(RF_ZERO_REG));
      if (xfer) begin
        wr_addr <= rd_sel;
        wr_data <= data_sel;
      end
    end
  end

endmodule
